operand_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/opfetch_scoreboard.sv | 51 +++++
 rtl/operand_fetch.sv | 120 ++++++++++++
 tb/tb_operand_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit pipeline.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int OP_W     = 4;
  localparam int IMM_W    = 8;

  // R0 reads as zero and is never tracked as an outstanding write.
  localparam logic [REG_W-1:0] R0 = '0;

  // True when a committing writeback targets a real register equal to idx.
  function automatic logic wb_hit(input logic             valid,
                                  input logic [REG_W-1:0] wb_idx,
                                  input logic [REG_W-1:0] idx);
    return valid && (wb_idx == idx) && (idx != R0);
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write mask for the operand-fetch stage: one bit per register,
// set when a writing instruction is accepted, cleared on writeback or when
// the instruction holding it is flushed.
module opfetch_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_W = cpu_pkg::REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_W-1:0]      set_idx,
  input  logic                  clr_en,
  input  logic [REG_W-1:0]      clr_idx,
  input  logic                  fl_en,
  input  logic [REG_W-1:0]      fl_idx,
  input  logic [REG_W-1:0]      q1_idx,
  input  logic [REG_W-1:0]      q2_idx,
  input  logic [REG_W-1:0]      q3_idx,
  output logic                  q1_pend,
  output logic                  q2_pend,
  output logic                  q3_pend,
  output logic [2**REG_W-1:0]   pending
);

  localparam int NUM = 2**REG_W;

  logic [NUM-1:0] pending_next;

  // Next mask: writeback clear, then accept set (set wins), then flush clear last.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    pending_next = pending;
    if (clr_en) pending_next[clr_idx] = 1'b0;
    if (set_en) pending_next[set_idx] = 1'b1;
    if (fl_en)  pending_next[fl_idx]  = 1'b0;
    pending_next[0] = 1'b0;
  end

  // Mask register; cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign q1_pend = pending[q1_idx];
  assign q2_pend = pending[q2_idx];
  assign q3_pend = pending[q3_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads the register file, bypasses a same-cycle
// writeback, stalls decode on RAW/WAW hazards and registers operands into a
// valid/ready output register for execute.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_W  = cpu_pkg::REG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_W-1:0]     in_rs1,
  input  logic [REG_W-1:0]     in_rs2,
  input  logic [REG_W-1:0]     in_rd,
  input  logic                 in_wr,
  input  logic [OP_W-1:0]      in_op,
  input  logic [IMM_W-1:0]     in_imm,
  output logic [REG_W-1:0]     rf_src1,
  output logic [REG_W-1:0]     rf_src2,
  input  logic [DATA_W-1:0]    rf_data1,
  input  logic [DATA_W-1:0]    rf_data2,
  input  logic                 wb_valid,
  input  logic [REG_W-1:0]     wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_a,
  output logic [DATA_W-1:0]    out_b,
  output logic [REG_W-1:0]     out_rd,
  output logic                 out_wr,
  output logic [OP_W-1:0]      out_op,
  output logic [IMM_W-1:0]     out_imm,
  output logic [15:0]          stall_count
);

  logic              byp1, byp2, wb_clr_rd;
  logic              pend1, pend2, pend_rd;
  logic              hazard, accept;
  logic [DATA_W-1:0] opnd_a, opnd_b;
  logic [2**REG_W-1:0] pending;

  assign rf_src1 = in_rs1;
  assign rf_src2 = in_rs2;

  assign byp1      = wb_hit(wb_valid, wb_rd, in_rs1);
  assign byp2      = wb_hit(wb_valid, wb_rd, in_rs2);
  assign wb_clr_rd = wb_hit(wb_valid, wb_rd, in_rd);

  // Operand select: R0 is zero, then writeback bypass, then register file.
  always_comb begin
    opnd_a = rf_data1;
    opnd_b = rf_data2;
    if (in_rs1 == R0)  opnd_a = '0;
    else if (byp1)     opnd_a = wb_data;
    if (in_rs2 == R0)  opnd_b = '0;
    else if (byp2)     opnd_b = wb_data;
  end

  // A pending source is fine if its writeback lands this cycle; R0 is never pending.
  assign hazard = in_valid &&
                  ((pend1 && !byp1) ||
                   (pend2 && !byp2) ||
                   (in_wr && (in_rd != R0) && pend_rd && !wb_clr_rd));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  opfetch_scoreboard #(.REG_W(REG_W)) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept && in_wr && (in_rd != R0)),
    .set_idx (in_rd),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .fl_en   (flush && out_valid && out_wr && (out_rd != R0)),
    .fl_idx  (out_rd),
    .q1_idx  (in_rs1),
    .q2_idx  (in_rs2),
    .q3_idx  (in_rd),
    .q1_pend (pend1),
    .q2_pend (pend2),
    .q3_pend (pend_rd),
    .pending (pending)
  );

  // Output pipeline register: flush drops, accept loads, drain clears valid, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wr    <= 1'b0;
      out_op    <= '0;
      out_imm   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= opnd_a;
      out_b     <= opnd_b;
      out_rd    <= in_rd;
      out_wr    <= in_wr;
      out_op    <= in_op;
      out_imm   <= in_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles in which decode is held by a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  stall_count <= '0;
    else if (hazard && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for single-cycle behaviour
// plus hand-written hold, flush and mid-stall reset sequences.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        in_wr;
  logic [3:0]  in_op;
  logic [7:0]  in_imm;
  logic [3:0]  rf_src1, rf_src2;
  logic [15:0] rf_data1, rf_data2;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a, out_b;
  logic [3:0]  out_rd;
  logic        out_wr;
  logic [3:0]  out_op;
  logic [7:0]  out_imm;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr),
    .in_op(in_op), .in_imm(in_imm),
    .rf_src1(rf_src1), .rf_src2(rf_src2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wr(out_wr),
    .out_op(out_op), .out_imm(out_imm),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rs1, rs2, rd;
    logic        wr;
    logic [3:0]  op;
    logic [7:0]  imm;
    logic [15:0] rf1, rf2;
    logic        wbv;
    logic [3:0]  wbr;
    logic [15:0] wbd;
    logic        exp_ready;
    logic [15:0] exp_a, exp_b;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic wr,
                       input logic [15:0] rf1, input logic [15:0] rf2);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr = wr;
    rf_data1 = rf1; rf_data2 = rf2;
  endtask

  initial begin
    // rs1 rs2 rd wr op imm rf1 rf2 wbv wbr wbd | ready a b
    vecs[0]  = '{4'd1, 4'd2, 4'd3, 1'b1, 4'h0, 8'h10, 16'h0005, 16'h000A, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0005, 16'h000A};
    vecs[1]  = '{4'd3, 4'd0, 4'd5, 1'b1, 4'h1, 8'h11, 16'h1234, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{4'd3, 4'd0, 4'd5, 1'b1, 4'h2, 8'h12, 16'h1234, 16'hFFFF, 1'b1, 4'd3, 16'h000F, 1'b1, 16'h000F, 16'h0000};
    vecs[3]  = '{4'd0, 4'd7, 4'd0, 1'b1, 4'h3, 8'h13, 16'hFFFF, 16'h0077, 1'b1, 4'd0, 16'hBEEF, 1'b1, 16'h0000, 16'h0077};
    vecs[4]  = '{4'd0, 4'd0, 4'd0, 1'b1, 4'h4, 8'h14, 16'hAAAA, 16'h5555, 1'b0, 4'd0, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    vecs[5]  = '{4'd5, 4'd2, 4'd6, 1'b0, 4'h5, 8'h15, 16'h0001, 16'h0202, 1'b1, 4'd2, 16'h2222, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{4'd5, 4'd2, 4'd6, 1'b0, 4'h6, 8'h16, 16'h0001, 16'h0202, 1'b1, 4'd5, 16'h5555, 1'b1, 16'h5555, 16'h0202};
    vecs[7]  = '{4'd9, 4'd9, 4'd9, 1'b1, 4'h7, 8'h17, 16'h0909, 16'h0909, 1'b1, 4'd9, 16'h9999, 1'b1, 16'h9999, 16'h9999};
    vecs[8]  = '{4'd1, 4'd1, 4'd9, 1'b1, 4'h8, 8'h18, 16'h0101, 16'h0101, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[9]  = '{4'd1, 4'd1, 4'd9, 1'b1, 4'h9, 8'h19, 16'h0101, 16'h0101, 1'b1, 4'd9, 16'h1111, 1'b1, 16'h0101, 16'h0101};
    vecs[10] = '{4'd9, 4'd1, 4'd2, 1'b0, 4'hA, 8'h1A, 16'h0909, 16'h0101, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[11] = '{4'd9, 4'd1, 4'd2, 1'b0, 4'hB, 8'h1B, 16'h0909, 16'h0101, 1'b1, 4'd9, 16'hABCD, 1'b1, 16'hABCD, 16'h0101};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; in_op = '0; in_imm = '0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);

    // Reset state before any clock edge.
    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_a", out_a, 0);
    check("reset_stall_count", stall_count, 0);
    check("reset_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;

    // Table-driven single-cycle vectors with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wr, vecs[i].rf1, vecs[i].rf2);
      in_op = vecs[i].op; in_imm = vecs[i].imm;
      wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbr; wb_data = vecs[i].wbd;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_ready);
      check($sformatf("v%0d_rf_src1", i), rf_src1, vecs[i].rs1);
      if (!vecs[i].exp_ready) exp_stall++;
      tick();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ready);
      if (vecs[i].exp_ready) begin
        check($sformatf("v%0d_out_a", i), out_a, vecs[i].exp_a);
        check($sformatf("v%0d_out_b", i), out_b, vecs[i].exp_b);
        check($sformatf("v%0d_out_rd", i), out_rd, vecs[i].rd);
        check($sformatf("v%0d_out_wr", i), out_wr, vecs[i].wr);
        check($sformatf("v%0d_out_op", i), out_op, vecs[i].op);
        check($sformatf("v%0d_out_imm", i), out_imm, vecs[i].imm);
      end
      check($sformatf("v%0d_stall_count", i), stall_count, exp_stall);
    end

    // Hold: back-pressure keeps outputs stable, then resumes with no bubble.
    wb_valid = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
    tick();
    check("drain_out_valid", out_valid, 0);
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd2, 4'd10, 1'b1, 16'h1111, 16'h2222);
    in_op = 4'hC; in_imm = 8'hC0;
    tick();
    check("hold_load_a", out_a, 16'h1111);
    drive(1'b1, 4'd3, 4'd4, 4'd11, 1'b0, 16'h3333, 16'h4444);
    in_op = 4'hD; in_imm = 8'hD0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d_in_ready", c), in_ready, 0);
      tick();
      check($sformatf("hold%0d_out_valid", c), out_valid, 1);
      check($sformatf("hold%0d_out_a", c), out_a, 16'h1111);
      check($sformatf("hold%0d_out_b", c), out_b, 16'h2222);
      check($sformatf("hold%0d_out_rd", c), out_rd, 10);
      check($sformatf("hold%0d_out_op", c), out_op, 4'hC);
    end
    check("hold_no_stall_count", stall_count, exp_stall);
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", in_ready, 1);
    tick();
    check("resume_out_valid", out_valid, 1);
    check("resume_out_a", out_a, 16'h3333);
    check("resume_out_rd", out_rd, 11);
    check("resume_out_imm", out_imm, 8'hD0);

    // Flush: drop a held writer of R6 and release its pending bit; R10 stays pending.
    drive(1'b1, 4'd0, 4'd0, 4'd6, 1'b1, 16'h7777, 16'h8888);
    tick();
    check("flush_load_rd", out_rd, 6);
    out_ready = 1'b0; flush = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0);
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    drive(1'b1, 4'd10, 4'd0, 4'd0, 1'b0, 16'h0A0A, 16'h0);
    #1;
    check("r10_still_pending", in_ready, 0);
    drive(1'b1, 4'd6, 4'd0, 4'd0, 1'b0, 16'h0606, 16'h0);
    #1;
    check("r6_released", in_ready, 1);
    tick();
    check("r6_read_out_a", out_a, 16'h0606);

    // Reset mid-stall and mid-hold.
    drive(1'b1, 4'd10, 4'd0, 4'd0, 1'b0, 16'h0A0A, 16'h0);
    tick();
    tick();
    exp_stall += 2;
    check("stall_two_cycles", stall_count, exp_stall);
    check("stall_hold_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_a", out_a, 0);
    check("async_rst_out_rd", out_rd, 0);
    check("async_rst_out_op", out_op, 0);
    check("async_rst_stall", stall_count, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_r10_free", in_ready, 1);
    in_valid = 1'b0; in_rs2 = 4'd13;
    #1;
    check("rf_src2_follow", rf_src2, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
